// File: rtl/riscv_multicycle_sequencer_if.sv
// Memory request/response bundle shared between the sequencer (master) and the
// single-port instruction/data memory (slave).
interface riscv_multicycle_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr_sel,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr_sel,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle RV32 control FSM (lw/sw/addi/add/sub) driving datapath strobes.
// Define RISCV_SEQ_RETIRE_COUNT_EN to build the 32-bit retired-instruction counter.
module riscv_multicycle_sequencer (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  riscv_multicycle_sequencer_if.master        mem,
  output logic [31:0]                         instr,
  output logic [2:0]                          alu_ctrl,
  output logic                                alu_b_source,
  output logic                                reg_write_enable,
  output logic                                reg_write_data_source,
  output logic                                pc_write,
  output logic [2:0]                          state,
  output logic                                illegal,
  output logic [31:0]                         retired_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_LW   = 3'd1,
    CL_SW   = 3'd2,
    CL_ADDI = 3'd3,
    CL_ADD  = 3'd4,
    CL_SUB  = 3'd5
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  cls_t        dec_cls;
  logic [31:0] instr_q, instr_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  always_comb begin
    dec_cls = CL_NONE;
    unique case (instr_q[6:0])
      7'b0000011: if (instr_q[14:12] == 3'b010) dec_cls = CL_LW;
      7'b0100011: if (instr_q[14:12] == 3'b010) dec_cls = CL_SW;
      7'b0010011: if (instr_q[14:12] == 3'b000) dec_cls = CL_ADDI;
      7'b0110011: begin
        if (instr_q[14:12] == 3'b000 && instr_q[31:25] == 7'b0000000) dec_cls = CL_ADD;
        if (instr_q[14:12] == 3'b000 && instr_q[31:25] == 7'b0100000) dec_cls = CL_SUB;
      end
      default: dec_cls = CL_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cls_q     <= CL_NONE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    unique case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (mem.mem_ready) begin
                instr_d = mem.mem_rdata;
                state_d = DECODE;
              end
      DECODE: if (dec_cls == CL_NONE) begin
                illegal_d = 1'b1;
                state_d   = TRAP;
              end else begin
                cls_d   = dec_cls;
                state_d = EXEC;
              end
      EXEC:   state_d = (cls_q == CL_LW || cls_q == CL_SW) ? MEM : WB;
      MEM:    if (mem.mem_ready && cls_q == CL_LW) state_d = WB;
      WB:     state_d = state_q;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // Both retire points (WB, and sw completing in MEM) share the run check.
    if (retire) state_d = run ? FETCH : IDLE;
  end

  always_comb begin
    mem.mem_req           = 1'b0;
    mem.mem_we            = 1'b0;
    mem.mem_addr_sel      = 1'b0;
    alu_ctrl              = 3'b000;
    alu_b_source          = 1'b0;
    reg_write_enable      = 1'b0;
    reg_write_data_source = 1'b0;
    retire                = 1'b0;
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      alu_ctrl     = (cls_q == CL_SUB) ? 3'b001 : 3'b000;
      alu_b_source = (cls_q == CL_LW || cls_q == CL_SW || cls_q == CL_ADDI);
    end
    unique case (state_q)
      FETCH: mem.mem_req = 1'b1;
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (cls_q == CL_SW);
        retire           = (cls_q == CL_SW) && mem.mem_ready;
      end
      WB: begin
        reg_write_enable      = 1'b1;
        reg_write_data_source = (cls_q == CL_LW);
        retire                = 1'b1;
      end
      default: ;
    endcase
    pc_write = retire;
  end

  assign instr   = instr_q;
  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef RISCV_SEQ_RETIRE_COUNT_EN
  logic [31:0] retired_count_q, retired_count_d;

  always_comb retired_count_d = retired_count_q + (pc_write ? 32'd1 : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_count_q <= '0;
    else       retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// Directed self-checking bench for riscv_multicycle_sequencer.
module tb_riscv_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] instr;
  logic [2:0]  alu_ctrl;
  logic        alu_b_source;
  logic        reg_write_enable;
  logic        reg_write_data_source;
  logic        pc_write;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired_count;

  int tests;
  int failures;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0040A103;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_ADDI = 32'h00108093;

`ifdef RISCV_SEQ_RETIRE_COUNT_EN
  localparam logic [31:0] CNT4 = 32'd4;
  localparam logic [31:0] CNT3 = 32'd3;
`else
  localparam logic [31:0] CNT4 = 32'd0;
  localparam logic [31:0] CNT3 = 32'd0;
`endif

  riscv_multicycle_sequencer_if mif ();

  riscv_multicycle_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .run                   (run),
    .mem                   (mif),
    .instr                 (instr),
    .alu_ctrl              (alu_ctrl),
    .alu_b_source          (alu_b_source),
    .reg_write_enable      (reg_write_enable),
    .reg_write_data_source (reg_write_data_source),
    .pc_write              (pc_write),
    .state                 (state),
    .illegal               (illegal),
    .retired_count         (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-low-phase.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    failures = 0;
    reset = 1'b1;
    run = 1'b0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;

    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_pcw", 32'(pc_write), 32'd0);
    chk("rst_alu", 32'(alu_ctrl), 32'd0);
    reset = 1'b0;

    step();
    chk("idle_hold", 32'(state), 32'd0);
    run = 1'b1;

    // add, zero wait: 1,2,3,5
    step();
    chk("add_fetch_state", 32'(state), 32'd1);
    chk("add_fetch_req", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b100);
    mif.mem_ready = 1'b1; mif.mem_rdata = I_ADD;
    step();
    mif.mem_ready = 1'b0;
    chk("add_dec_state", 32'(state), 32'd2);
    chk("add_instr", instr, I_ADD);
    chk("add_dec_req", 32'(mif.mem_req), 32'd0);
    step();
    chk("add_exec_state", 32'(state), 32'd3);
    chk("add_exec_alu", {28'd0, alu_ctrl, alu_b_source}, 32'b0000);
    step();
    chk("add_wb_state", 32'(state), 32'd5);
    chk("add_wb_strobes", {28'd0, alu_ctrl, alu_b_source}, 32'b0000);
    chk("add_wb_we_pcw", {29'd0, reg_write_enable, pc_write, reg_write_data_source}, 32'b110);
    step();
    chk("add_refetch", 32'(state), 32'd1);

    // sub with three wait cycles in FETCH
    for (int i = 0; i < 3; i++) begin
      chk("sub_wait_req", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b100);
      chk("sub_wait_state", 32'(state), 32'd1);
      step();
    end
    chk("sub_req4", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b100);
    mif.mem_ready = 1'b1; mif.mem_rdata = I_SUB;
    step();
    mif.mem_ready = 1'b0;
    chk("sub_dec_state", 32'(state), 32'd2);
    step();
    chk("sub_exec_alu", 32'(alu_ctrl), 32'b001);
    step();
    chk("sub_wb_alu", {28'd0, alu_ctrl, alu_b_source}, 32'b0010);
    chk("sub_wb_we", {30'd0, reg_write_enable, pc_write}, 32'b11);
    step();

    // lw: 1,2,3,4,5
    chk("lw_fetch_state", 32'(state), 32'd1);
    mif.mem_ready = 1'b1; mif.mem_rdata = I_LW;
    step();
    mif.mem_ready = 1'b0;
    chk("lw_dec_state", 32'(state), 32'd2);
    step();
    chk("lw_exec", {28'd0, state, alu_b_source}, {28'd0, 3'd3, 1'b1});
    step();
    chk("lw_mem_state", 32'(state), 32'd4);
    chk("lw_mem_req", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b101);
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_mem_pcw", 32'(pc_write), 32'd0);
    step();
    mif.mem_ready = 1'b0;
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb_src", {28'd0, reg_write_enable, reg_write_data_source, pc_write, alu_b_source}, 32'b1111);
    step();

    // sw with one wait cycle in MEM, run dropped at retire
    chk("sw_fetch_state", 32'(state), 32'd1);
    mif.mem_ready = 1'b1; mif.mem_rdata = I_SW;
    step();
    mif.mem_ready = 1'b0;
    step();
    chk("sw_exec_state", 32'(state), 32'd3);
    step();
    chk("sw_mem_req", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b111);
    chk("sw_mem_wait_pcw", 32'(pc_write), 32'd0);
    step();
    chk("sw_mem_hold", {29'd0, mif.mem_req, mif.mem_we, mif.mem_addr_sel}, 32'b111);
    mif.mem_ready = 1'b1;
    run = 1'b0;
    #1;
    chk("sw_retire", {30'd0, pc_write, reg_write_enable}, 32'b10);
    step();
    mif.mem_ready = 1'b0;
    chk("sw_idle_state", 32'(state), 32'd0);
    chk("sw_idle_req", 32'(mif.mem_req), 32'd0);
    chk("count_after4", retired_count, CNT4);

    // illegal instruction -> TRAP, run toggling has no effect
    run = 1'b1;
    step();
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'h0;
    step();
    mif.mem_ready = 1'b0;
    step();
    chk("trap_state", 32'(state), 32'd6);
    chk("trap_illegal", 32'(illegal), 32'd1);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step();
      chk("trap_hold", {28'd0, state, illegal}, {28'd0, 3'd6, 1'b1});
      chk("trap_quiet", {29'd0, mif.mem_req, pc_write, reg_write_enable}, 32'b000);
    end

    reset = 1'b1;
    #1;
    chk("trap_reset", {28'd0, state, illegal}, 32'd0);
    reset = 1'b0;
    run = 1'b1;
    step();
    chk("rf_fetch_req", 32'(mif.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rf_async_req", 32'(mif.mem_req), 32'd0);
    chk("rf_async_state", 32'(state), 32'd0);
    #1;
    reset = 1'b0;

    // three addi retires from a clean reset
    step();
    for (int i = 0; i < 3; i++) begin
      mif.mem_ready = 1'b1; mif.mem_rdata = I_ADDI;
      step();
      mif.mem_ready = 1'b0;
      step();
      chk("addi_exec", {27'd0, state, alu_ctrl[0], alu_b_source}, {27'd0, 3'd3, 1'b0, 1'b1});
      step();
      chk("addi_wb", {29'd0, reg_write_enable, pc_write, reg_write_data_source}, 32'b110);
      if (i == 2) run = 1'b0;
      step();
    end
    chk("addi_idle", 32'(state), 32'd0);
    chk("count_after3", retired_count, CNT3);

`ifdef RISCV_SEQ_RETIRE_COUNT_EN
    force dut.retired_count_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_count_q;
    #1;
    chk("count_forced", retired_count, 32'hFFFFFFFF);
`endif
    run = 1'b1;
    step();
    mif.mem_ready = 1'b1; mif.mem_rdata = I_ADD;
    step();
    mif.mem_ready = 1'b0;
    step();
    step();
    chk("wrap_wb_pcw", 32'(pc_write), 32'd1);
    run = 1'b0;
    step();
    chk("wrap_idle", 32'(state), 32'd0);
    chk("count_wrap", retired_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
